// File: rtl/jtoutrun_subbus_arb.sv
// Main-CPU side arbiter for the OutRun sub bus: 68000-style BR/BGACK handshake,
// access forwarding, a hold window for back-to-back accesses and a grant timeout.
module jtoutrun_subbus_arb #(
  parameter int unsigned HOLD = 8,
  parameter int unsigned TMO  = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        main_cs_i,
  input  logic [19:1] main_a_i,
  input  logic [1:0]  main_dsn_i,
  input  logic        main_rnw_i,
  input  logic [15:0] main_dout_i,
  output logic [15:0] main_din_o,
  output logic        main_ok_o,
  output logic        sub_br_o,
  input  logic        sub_bgackn_i,
  output logic        sub_cs_o,
  output logic [19:1] sub_a_o,
  output logic [1:0]  sub_dsn_o,
  output logic        sub_rnw_o,
  output logic [15:0] sub_dout_o,
  input  logic [15:0] sub_din_i,
  input  logic        sub_ok_i,
  output logic        err_o,
  output logic        busy_o
);

  localparam int unsigned TmoW  = (TMO > 1) ? $clog2(TMO) : 1;
  localparam int unsigned HoldW = $clog2(HOLD) + 1;
  localparam logic [TmoW-1:0]  TmoLast  = TmoW'(TMO - 1);
  localparam logic [HoldW-1:0] HoldLoad = HoldW'(HOLD - 1);

  typedef enum logic [2:0] {StIdle, StReq, StAccess, StDone, StHold, StErr} state_e;

  state_e           state_q;
  logic [TmoW-1:0]  tmo_cnt_q;
  logic [HoldW-1:0] hold_cnt_q;
  logic             sub_br_q, sub_cs_q, main_ok_q, err_q, busy_q;
  logic [15:0]      main_din_q;
  logic [19:1]      sub_a_q;
  logic [1:0]       sub_dsn_q;
  logic             sub_rnw_q;
  logic [15:0]      sub_dout_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      tmo_cnt_q  <= '0;
      hold_cnt_q <= '0;
      sub_br_q   <= 1'b0;
      sub_cs_q   <= 1'b0;
      main_ok_q  <= 1'b0;
      main_din_q <= '0;
      sub_a_q    <= '0;
      sub_dsn_q  <= 2'b11;
      sub_rnw_q  <= 1'b1;
      sub_dout_q <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (main_cs_i) begin
            state_q    <= StReq;
            sub_br_q   <= 1'b1;
            busy_q     <= 1'b1;
            tmo_cnt_q  <= '0;
            sub_a_q    <= main_a_i;
            sub_dsn_q  <= main_dsn_i;
            sub_rnw_q  <= main_rnw_i;
            sub_dout_q <= main_dout_i;
          end
        end
        StReq: begin
          if (tmo_cnt_q != TmoLast) tmo_cnt_q <= tmo_cnt_q + TmoW'(1);
          // A grant on the last counted cycle still wins over the timeout
          if (!sub_bgackn_i) begin
            state_q  <= StAccess;
            sub_cs_q <= 1'b1;
          end else if (tmo_cnt_q == TmoLast) begin
            state_q <= StErr;
          end
        end
        StAccess: begin
          if (sub_ok_i) begin
            state_q   <= StDone;
            main_ok_q <= 1'b1;
            sub_cs_q  <= 1'b0;
            if (sub_rnw_q) main_din_q <= sub_din_i;
          end else if (sub_bgackn_i) begin
            state_q   <= StReq;
            sub_cs_q  <= 1'b0;
            tmo_cnt_q <= '0;
          end
        end
        StDone: begin
          if (!main_cs_i) begin
            state_q    <= StHold;
            main_ok_q  <= 1'b0;
            hold_cnt_q <= HoldLoad;
          end
        end
        StHold: begin
          if (main_cs_i) begin
            sub_a_q    <= main_a_i;
            sub_dsn_q  <= main_dsn_i;
            sub_rnw_q  <= main_rnw_i;
            sub_dout_q <= main_dout_i;
            if (!sub_bgackn_i) begin
              state_q  <= StAccess;
              sub_cs_q <= 1'b1;
            end else begin
              state_q   <= StReq;
              tmo_cnt_q <= '0;
            end
          end else if (hold_cnt_q == '0) begin
            state_q  <= StIdle;
            sub_br_q <= 1'b0;
            busy_q   <= 1'b0;
          end else begin
            hold_cnt_q <= hold_cnt_q - HoldW'(1);
          end
        end
        StErr: begin
          main_din_q <= 16'hFFFF;
          err_q      <= 1'b1;
          sub_br_q   <= 1'b0;
          if (main_cs_i) begin
            main_ok_q <= 1'b1;
          end else begin
            main_ok_q <= 1'b0;
            state_q   <= StIdle;
            busy_q    <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign main_din_o = main_din_q;
  assign main_ok_o  = main_ok_q;
  assign sub_br_o   = sub_br_q;
  assign sub_cs_o   = sub_cs_q;
  assign sub_a_o    = sub_a_q;
  assign sub_dsn_o  = sub_dsn_q;
  assign sub_rnw_o  = sub_rnw_q;
  assign sub_dout_o = sub_dout_q;
  assign err_o      = err_q;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_jtoutrun_subbus_arb.sv
// Bench for jtoutrun_subbus_arb: directed vector table, hand-written corner sequences
// and a randomized transaction stream checked against a transaction-level model.
module tb_jtoutrun_subbus_arb;

  localparam int Hold = 8;
  localparam int Tmo  = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        main_cs, main_rnw, main_ok, sub_br, sub_bgackn, sub_cs, sub_rnw, sub_ok;
  logic        err, busy;
  logic [19:1] main_a, sub_a;
  logic [1:0]  main_dsn, sub_dsn;
  logic [15:0] main_dout, main_din, sub_dout, sub_din;

  jtoutrun_subbus_arb #(.HOLD(Hold), .TMO(Tmo)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .main_cs_i    (main_cs),
    .main_a_i     (main_a),
    .main_dsn_i   (main_dsn),
    .main_rnw_i   (main_rnw),
    .main_dout_i  (main_dout),
    .main_din_o   (main_din),
    .main_ok_o    (main_ok),
    .sub_br_o     (sub_br),
    .sub_bgackn_i (sub_bgackn),
    .sub_cs_o     (sub_cs),
    .sub_a_o      (sub_a),
    .sub_dsn_o    (sub_dsn),
    .sub_rnw_o    (sub_rnw),
    .sub_dout_o   (sub_dout),
    .sub_din_i    (sub_din),
    .sub_ok_i     (sub_ok),
    .err_o        (err),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Sub-side environment: grants after grant_delay cycles of BR, answers after ok_delay
  int          grant_delay, ok_delay, br_cnt, cs_cnt, steal, ok_pulses;
  logic [15:0] rdata;

  typedef struct {
    logic [15:0] din;
    int          lat;
    logic        held;
    logic        br_kept;
    logic        br_ack;
    logic [37:0] fields;
    logic        ok_fell;
    logic        busy_ack;
  } res_t;

  typedef struct {
    logic [18:0] a;
    logic [1:0]  dsn;
    logic        rnw;
    logic [15:0] wd;
    logic [15:0] rd;
    int          gd;
    int          okd;
    int          gap;
    logic        exp_held;
    int          exp_lat;
    logic [15:0] exp_din;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (steal > 0) begin
      sub_bgackn = 1'b1;
      steal--;
      br_cnt = 0;
    end else if (!sub_br) begin
      sub_bgackn = 1'b1;
      br_cnt = 0;
    end else if (sub_bgackn) begin
      br_cnt++;
      if (br_cnt >= grant_delay) sub_bgackn = 1'b0;
    end
    sub_ok  = 1'b0;
    sub_din = 16'($urandom);
    if (sub_cs) begin
      cs_cnt++;
      if (cs_cnt >= ok_delay) begin
        sub_ok  = 1'b1;
        sub_din = rdata;
        ok_pulses++;
      end
    end else begin
      cs_cnt = 0;
    end
  endtask

  task automatic run_txn(input logic [18:0] a, input logic [1:0] dsn, input logic rnw,
                         input logic [15:0] wd, input logic [15:0] rd, input int gd,
                         input int okd, input int gap, output res_t r);
    bit got = 0;
    r.held = sub_br;
    r.br_kept = sub_br;
    r.lat = -1;
    r.fields = 'x;
    grant_delay = gd;
    ok_delay = okd;
    rdata = rd;
    main_a = a; main_dsn = dsn; main_rnw = rnw; main_dout = wd; main_cs = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (!sub_br) r.br_kept = 1'b0;
      if (sub_cs && !got) begin
        got = 1;
        r.fields = {sub_a, sub_dsn, sub_rnw, sub_dout};
      end
      if (main_ok) begin
        r.lat = i;
        break;
      end
    end
    r.din = main_din;
    r.br_ack = sub_br;
    r.busy_ack = busy;
    // Scramble the main-side fields so any late relatch would be visible
    main_cs = 1'b0; main_a = ~a; main_dsn = ~dsn; main_rnw = ~rnw; main_dout = ~wd;
    step();
    r.ok_fell = !main_ok;
    repeat (gap) step();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t        vecs[6];
    res_t        r;
    bit          seen;
    logic [15:0] m_din;
    logic        m_err, m_prev_ok, exp_held, exp_to;
    int          m_prev_gap, exp_lat;
    logic [18:0] ra;
    logic [1:0]  rdsn;
    logic        rrnw;
    logic [15:0] rwd, rrd, exp_din;
    int          rgd, rokd, rgap;

    //           a           dsn    rnw   wd        rd        gd   okd gap     held  lat din
    vecs[0] = '{19'h30000, 2'b00, 1'b1, 16'h0000, 16'h1234, 3,   4,  2,      1'b0, 8,  16'h1234};
    vecs[1] = '{19'h30001, 2'b00, 1'b0, 16'hBEEF, 16'h0000, 3,   2,  Hold-1, 1'b1, 3,  16'h1234};
    vecs[2] = '{19'h00010, 2'b10, 1'b1, 16'h5555, 16'hA5A5, 3,   1,  Hold,   1'b1, 2,  16'hA5A5};
    vecs[3] = '{19'h7FFFF, 2'b01, 1'b1, 16'h0001, 16'h0F0F, Tmo, 3,  20,     1'b0, 20, 16'h0F0F};
    vecs[4] = '{19'h12345, 2'b00, 1'b0, 16'hC001, 16'h9999, 1,   1,  3,      1'b0, 3,  16'h0F0F};
    vecs[5] = '{19'h00000, 2'b00, 1'b1, 16'h7E7E, 16'hFFFE, 5,   5,  30,     1'b1, 6,  16'hFFFE};

    grant_delay = 1; ok_delay = 1; br_cnt = 0; cs_cnt = 0; steal = 0; ok_pulses = 0;
    rdata = 16'h0;
    rst = 1'b1; main_cs = 1'b0; main_a = '0; main_dsn = 2'b11; main_rnw = 1'b1;
    main_dout = '0; sub_bgackn = 1'b1; sub_ok = 1'b0; sub_din = '0;
    repeat (3) step();
    chk("reset_values",
        {sub_br, sub_cs, main_ok, main_din, sub_a, sub_dsn, sub_rnw, sub_dout, err, busy},
        {1'b0, 1'b0, 1'b0, 16'h0, 19'h0, 2'b11, 1'b1, 16'h0, 1'b0, 1'b0});
    rst = 1'b0;
    step();

    foreach (vecs[i]) begin
      run_txn(vecs[i].a, vecs[i].dsn, vecs[i].rnw, vecs[i].wd, vecs[i].rd, vecs[i].gd,
              vecs[i].okd, vecs[i].gap, r);
      chk($sformatf("vec%0d_held", i), r.held, vecs[i].exp_held);
      chk($sformatf("vec%0d_br_kept", i), r.br_kept, vecs[i].exp_held);
      chk($sformatf("vec%0d_latency", i), r.lat, vecs[i].exp_lat);
      chk($sformatf("vec%0d_din", i), r.din, vecs[i].exp_din);
      chk($sformatf("vec%0d_fields", i), r.fields,
          {vecs[i].a, vecs[i].dsn, vecs[i].rnw, vecs[i].wd});
      chk($sformatf("vec%0d_ok_fell", i), r.ok_fell, 1'b1);
      chk($sformatf("vec%0d_busy_br", i), {r.busy_ack, r.br_ack}, 2'b11);
      chk($sformatf("vec%0d_err", i), err, 1'b0);
    end

    // Grant never arrives: error response TMO+1 clks after BR
    run_txn(19'h00ABC, 2'b00, 1'b1, 16'h0, 16'h1111, 1000, 1, 2, r);
    chk("tmo_latency", r.lat, Tmo + 2);
    chk("tmo_din", r.din, 16'hFFFF);
    chk("tmo_br_dropped", r.br_ack, 1'b0);
    chk("tmo_err", err, 1'b1);
    chk("tmo_ok_fell", r.ok_fell, 1'b1);
    run_txn(19'h00ABD, 2'b00, 1'b0, 16'h2222, 16'h0, 2, 1, 20, r);
    chk("post_tmo_held", r.held, 1'b0);
    chk("post_tmo_latency", r.lat, 4);
    chk("post_tmo_din", r.din, 16'hFFFF);
    chk("err_sticky", err, 1'b1);

    // Bus lost during ACCESS, then regranted
    grant_delay = 2; ok_delay = 6; rdata = 16'h5A5A; ok_pulses = 0;
    main_a = 19'h0ABCD; main_dsn = 2'b01; main_rnw = 1'b1; main_dout = 16'h0; main_cs = 1'b1;
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      step();
      seen = sub_cs;
    end
    chk("lost_first_cs", seen, 1'b1);
    main_a = 19'h11111; main_dsn = 2'b10; main_dout = 16'hDEAD;
    steal = 3;
    step();
    step();
    chk("lost_cs_drop", {sub_cs, sub_br, busy}, 3'b011);
    seen = 0;
    r.fields = 'x;
    for (int i = 0; i < 100 && !main_ok; i++) begin
      step();
      if (sub_cs && !seen) begin
        seen = 1;
        r.fields = {sub_a, sub_dsn, sub_rnw, sub_dout};
      end
    end
    chk("lost_regrant_fields", r.fields, {19'h0ABCD, 2'b01, 1'b1, 16'h0});
    chk("lost_din", {main_ok, main_din}, {1'b1, 16'h5A5A});
    chk("lost_single_access", ok_pulses, 1);
    main_cs = 1'b0;
    repeat (20) step();

    // Reset while in ACCESS
    grant_delay = 2; ok_delay = 50;
    main_a = 19'h44444; main_dsn = 2'b00; main_rnw = 1'b0; main_dout = 16'h3333; main_cs = 1'b1;
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      step();
      seen = sub_cs;
    end
    chk("rst_reached_access", seen, 1'b1);
    rst = 1'b1; main_cs = 1'b0;
    step();
    chk("rst_mid_access",
        {sub_br, sub_cs, main_ok, main_din, sub_a, sub_dsn, sub_rnw, sub_dout, err, busy},
        {1'b0, 1'b0, 1'b0, 16'h0, 19'h0, 2'b11, 1'b1, 16'h0, 1'b0, 1'b0});
    rst = 1'b0;
    step();
    run_txn(19'h22222, 2'b00, 1'b1, 16'h0, 16'h7777, 2, 2, 20, r);
    chk("post_rst_fresh_req", r.held, 1'b0);
    chk("post_rst_latency", r.lat, 5);
    chk("post_rst_din", r.din, 16'h7777);

    // Randomized stream against a transaction-level model
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    m_din = 16'h0; m_err = 1'b0; m_prev_ok = 1'b0; m_prev_gap = 0;
    for (int n = 0; n < 40; n++) begin
      ra = 19'($urandom); rdsn = 2'($urandom); rrnw = 1'($urandom);
      rwd = 16'($urandom); rrd = 16'($urandom);
      rgd = int'($urandom_range(1, Tmo + 3));
      rokd = int'($urandom_range(1, 5));
      rgap = int'($urandom_range(0, 2 * Hold));
      // Bus still owned if the previous access succeeded and the gap fits the hold window
      exp_held = m_prev_ok && (m_prev_gap < Hold);
      exp_to = !exp_held && (rgd > Tmo);
      exp_lat = exp_to ? Tmo + 2 : (exp_held ? 1 : rgd + 1) + rokd;
      exp_din = exp_to ? 16'hFFFF : (rrnw ? rrd : m_din);
      m_err = m_err | exp_to;
      run_txn(ra, rdsn, rrnw, rwd, rrd, rgd, rokd, rgap, r);
      chk($sformatf("rand%0d_held", n), r.held, exp_held);
      chk($sformatf("rand%0d_latency", n), r.lat, exp_lat);
      chk($sformatf("rand%0d_din", n), r.din, exp_din);
      chk($sformatf("rand%0d_err", n), err, m_err);
      if (!exp_to) chk($sformatf("rand%0d_fields", n), r.fields, {ra, rdsn, rrnw, rwd});
      m_din = exp_din;
      m_prev_ok = !exp_to;
      m_prev_gap = rgap;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
